// File: rtl/serial_tx_port.sv
// Transmit side of the 8N1 serial link: one-byte holding register feeding a shifter,
// framed as start bit, D0..D7 LSB first, then STOP_BITS stop bits.
module serial_tx_port #(
  parameter int unsigned DIVISOR   = 16,
  parameter int unsigned STOP_BITS = 1
) (
  input  logic       CLK,
  input  logic       CLR,
  input  logic       WR,
  input  logic [7:0] D,
  output logic       TX,
  output logic       BUSY,
  output logic       FULL,
  output logic       DONE,
  output logic       OVR
);

  localparam int unsigned DIV_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIVISOR - 1);
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [2:0]       bit_q, bit_d;
  logic             stop_q, stop_d;
  logic [7:0]       hold_q, hold_d;
  logic [7:0]       shift_q, shift_d;
  logic             full_q, full_d;
  logic             tx_q, tx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             ovr_q, ovr_d;

  logic slot_end, frame_end, load;

  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      stop_q  <= 1'b0;
      hold_q  <= '0;
      shift_q <= '0;
      full_q  <= 1'b0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      stop_q  <= stop_d;
      hold_q  <= hold_d;
      shift_q <= shift_d;
      full_q  <= full_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_d     = bit_q;
    stop_d    = stop_q;
    hold_d    = hold_q;
    shift_d   = shift_q;
    full_d    = full_q;
    ovr_d     = ovr_q;
    slot_end  = (div_q == DIV_LAST);
    frame_end = (state_q == STOP) && slot_end && (stop_q == STOP_LAST);
    load      = full_q && ((state_q == IDLE) || frame_end);
    div_d     = slot_end ? '0 : div_q + DIV_W'(1);

    unique case (state_q)
      IDLE:  div_d = '0;
      START: if (slot_end) begin
        state_d = DATA;
        bit_d   = '0;
      end
      DATA: if (slot_end) begin
        shift_d = shift_q >> 1;
        bit_d   = bit_q + 3'd1;
        if (bit_q == 3'd7) begin
          state_d = STOP;
          stop_d  = 1'b0;
        end
      end
      STOP: if (slot_end) begin
        if (frame_end) state_d = IDLE;
        else           stop_d  = 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // A load frees the holding register on this same edge, so a coincident write is accepted.
    if (load) begin
      shift_d = hold_q;
      full_d  = 1'b0;
      state_d = START;
      div_d   = '0;
    end

    if (WR) begin
      if (!full_q || load) begin
        hold_d = D;
        full_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end

    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      default: tx_d = 1'b1;
    endcase
    busy_d = (state_d != IDLE) || full_d;
    // DONE is registered, so it is raised for the cycle whose closing edge ends the frame.
    done_d = (state_d == STOP) && (div_d == DIV_LAST) && (stop_d == STOP_LAST);
  end

  assign TX   = tx_q;
  assign BUSY = busy_q;
  assign FULL = full_q;
  assign DONE = done_q;
  assign OVR  = ovr_q;

endmodule

// File: tb/tb_serial_tx_port.sv
// Bench for serial_tx_port: directed writes with expected bytes queued per DUT, and
// monitors that decode the TX line and compare each received frame against the queue.
module tb_serial_tx_port;

  logic       clk = 1'b0;
  logic       clr_a, wr_a, clr_b, wr_b;
  logic [7:0] d_a, d_b;
  logic       tx_a, busy_a, full_a, done_a, ovr_a;
  logic       tx_b, busy_b, full_b, done_b, ovr_b;

  int checks = 0;
  int errors = 0;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  serial_tx_port #(.DIVISOR(4), .STOP_BITS(1)) dut_a (
    .CLK(clk), .CLR(clr_a), .WR(wr_a), .D(d_a),
    .TX(tx_a), .BUSY(busy_a), .FULL(full_a), .DONE(done_a), .OVR(ovr_a)
  );

  serial_tx_port #(.DIVISOR(1), .STOP_BITS(2)) dut_b (
    .CLK(clk), .CLR(clr_b), .WR(wr_b), .D(d_b),
    .TX(tx_b), .BUSY(busy_b), .FULL(full_b), .DONE(done_b), .OVR(ovr_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_a(input logic [7:0] b);
    wr_a = 1'b1;
    d_a  = b;
    tick();
    wr_a = 1'b0;
  endtask

  task automatic write_b(input logic [7:0] b);
    wr_b = 1'b1;
    d_b  = b;
    tick();
    wr_b = 1'b0;
  endtask

  // Monitor for DUT A (4 clocks per bit, 1 stop bit, 40-clock frame)
  bit         a_act = 1'b0;
  int         a_cnt = 0;
  logic [7:0] a_rx;
  always @(posedge clk) begin
    #1;
    if (clr_a) begin
      a_act = 1'b0;
    end else begin
      if (!a_act) begin
        if (tx_a == 1'b0) begin
          a_act = 1'b1;
          a_cnt = 1;
        end
      end else begin
        a_cnt++;
      end
      chk("a_done_timing", done_a, a_act && (a_cnt == 40));
      if (a_act) begin
        for (int j = 0; j < 8; j++) if (a_cnt == 4 * (j + 1) + 2) a_rx[j] = tx_a;
        if (a_cnt == 38) chk("a_stop_bit", tx_a, 1);
        if (a_cnt == 40) begin
          if (qa.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL a_unexpected_frame: got %0h expected none", a_rx);
          end else begin
            chk("a_frame_byte", a_rx, qa.pop_front());
          end
          a_act = 1'b0;
        end
      end
    end
  end

  // Monitor for DUT B (1 clock per bit, 2 stop bits, 11-clock frame)
  bit         b_act = 1'b0;
  int         b_cnt = 0;
  logic [7:0] b_rx;
  always @(posedge clk) begin
    #1;
    if (clr_b) begin
      b_act = 1'b0;
    end else begin
      if (!b_act) begin
        if (tx_b == 1'b0) begin
          b_act = 1'b1;
          b_cnt = 1;
        end
      end else begin
        b_cnt++;
      end
      chk("b_done_timing", done_b, b_act && (b_cnt == 11));
      if (b_act) begin
        for (int j = 0; j < 8; j++) if (b_cnt == j + 2) b_rx[j] = tx_b;
        if (b_cnt == 10 || b_cnt == 11) chk("b_stop_bit", tx_b, 1);
        if (b_cnt == 11) begin
          if (qb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL b_unexpected_frame: got %0h expected none", b_rx);
          end else begin
            chk("b_frame_byte", b_rx, qb.pop_front());
          end
          b_act = 1'b0;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic a5_seq [10] = '{0, 1, 0, 1, 0, 0, 1, 0, 1, 1};
    logic b80_seq[11] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};

    clr_a = 1'b1; clr_b = 1'b1;
    wr_a  = 1'b0; wr_b  = 1'b0;
    d_a   = '0;   d_b   = '0;
    repeat (3) tick();
    chk("rst_tx", tx_a, 1);
    chk("rst_busy", busy_a, 0);
    chk("rst_full", full_a, 0);
    chk("rst_done", done_a, 0);
    chk("rst_ovr", ovr_a, 0);
    chk("rst_b_tx", tx_b, 1);
    clr_a = 1'b0; clr_b = 1'b0;
    tick();

    // Single byte 0xA5: exact waveform, DONE on clock 40, BUSY drops after
    qa.push_back(8'hA5);
    write_a(8'hA5);
    chk("a5_full", full_a, 1);
    chk("a5_busy", busy_a, 1);
    chk("a5_tx_idle", tx_a, 1);
    for (int k = 1; k <= 40; k++) begin
      tick();
      chk("a5_tx_seq", tx_a, a5_seq[(k - 1) / 4]);
      chk("a5_done", done_a, (k == 40));
    end
    tick();
    chk("a5_busy_end", busy_a, 0);
    chk("a5_full_end", full_a, 0);

    // Back-to-back: 0x01 then 0xFF, FULL for whole first frame, no idle gap
    qa.push_back(8'h01);
    qa.push_back(8'hFF);
    write_a(8'h01);
    write_a(8'hFF);
    for (int k = 1; k <= 40; k++) begin
      if (k > 1) tick();
      chk("b2b_full", full_a, 1);
    end
    tick();
    chk("b2b_no_gap_tx", tx_a, 0);
    chk("b2b_full_clear", full_a, 0);
    chk("b2b_ovr", ovr_a, 0);
    repeat (41) tick();

    // Overrun: 0x33 dropped, OVR sticky
    qa.push_back(8'h11);
    qa.push_back(8'h22);
    write_a(8'h11);
    write_a(8'h22);
    write_a(8'h33);
    chk("ovr_set", ovr_a, 1);
    chk("ovr_full", full_a, 1);
    repeat (82) tick();
    chk("ovr_sticky", ovr_a, 1);
    chk("ovr_busy_end", busy_a, 0);

    // Asynchronous clear during data bit 3 of 0x5A, then a clean 0xC3 frame
    write_a(8'h5A);
    repeat (17) tick();
    #2 clr_a = 1'b1;
    #1;
    chk("clr_tx", tx_a, 1);
    chk("clr_busy", busy_a, 0);
    chk("clr_full", full_a, 0);
    chk("clr_ovr", ovr_a, 0);
    @(posedge clk);
    #3 clr_a = 1'b0;
    tick();
    qa.push_back(8'hC3);
    write_a(8'hC3);
    repeat (42) tick();
    chk("clr_ovr_after", ovr_a, 0);

    // Write on the edge that ends a frame with FULL=0
    qa.push_back(8'h3C);
    write_a(8'h3C);
    repeat (40) tick();
    chk("edge_done_hi", done_a, 1);
    chk("edge_full_lo", full_a, 0);
    qa.push_back(8'h96);
    write_a(8'h96);
    chk("edge_full_acc", full_a, 1);
    chk("edge_tx_idle", tx_a, 1);
    chk("edge_busy", busy_a, 1);
    chk("edge_ovr", ovr_a, 0);
    tick();
    chk("edge_start_tx", tx_a, 0);
    chk("edge_full_load", full_a, 0);
    repeat (42) tick();

    // DIVISOR=1, STOP_BITS=2, byte 0x80
    qb.push_back(8'h80);
    write_b(8'h80);
    chk("b80_full", full_b, 1);
    for (int k = 1; k <= 11; k++) begin
      tick();
      chk("b80_tx_seq", tx_b, b80_seq[k - 1]);
      chk("b80_done", done_b, (k == 11));
    end
    tick();
    chk("b80_busy_end", busy_b, 0);

    repeat (4) tick();
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
